// File: rtl/sha256_round_ctrl_if.sv
// Handshake and strobe bundle between the SHA-256 round sequencer and its
// surroundings (block-input FIFO, K ROM / W window, working and hash registers).
// The master modport is the sequencer; the slave modport is the datapath/source side.
// round_halt exists only when SHA_ROUND_HALT_EN is defined.
interface sha256_round_ctrl_if #(
   parameter int IDX_W  = 6,
   parameter int BCNT_W = 16
);
   logic              blk_valid;
   logic              blk_last;
   logic              blk_ready;
   logic [IDX_W-1:0]  k_index;
   logic              w_load;
   logic              w_expand;
   logic              round_en;
   logic              hash_init;
   logic              state_load;
   logic              hash_add;
   logic              digest_valid;
   logic              digest_ready;
   logic              busy;
   logic [BCNT_W-1:0] blk_cnt;
`ifdef SHA_ROUND_HALT_EN
   logic              round_halt;
`endif

   modport master (
      input  blk_valid, blk_last, digest_ready,
`ifdef SHA_ROUND_HALT_EN
      input  round_halt,
`endif
      output blk_ready, k_index, w_load, w_expand, round_en, hash_init,
             state_load, hash_add, digest_valid, busy, blk_cnt
   );

   modport slave (
      output blk_valid, blk_last, digest_ready,
`ifdef SHA_ROUND_HALT_EN
      output round_halt,
`endif
      input  blk_ready, k_index, w_load, w_expand, round_en, hash_init,
             state_load, hash_add, digest_valid, busy, blk_cnt
   );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts one 512-bit block per token, then
// walks LOAD -> ROUND x ROUNDS -> ADD, and presents the digest after the last
// block of a message until the consumer takes it.
// Optional feature: define SHA_ROUND_HALT_EN to add round_halt, which freezes
// the round counter while in ROUND.
module sha256_round_ctrl #(
   parameter int ROUNDS = 64,
   parameter int IDX_W  = 6,
   parameter int BCNT_W = 16
) (
   input logic                  clk,
   input logic                  rst,
   sha256_round_ctrl_if.master  bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ROUND = 3'd2;
   localparam logic [2:0] S_ADD   = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [IDX_W-1:0] LAST_T      = IDX_W'(ROUNDS - 1);
   localparam logic [IDX_W-1:0] LOAD_ROUNDS = IDX_W'(16);

   if (ROUNDS <= 16 || ROUNDS > (1 << IDX_W)) begin : g_bad_rounds
      $error("sha256_round_ctrl: ROUNDS must satisfy 16 < ROUNDS <= 2**IDX_W");
   end

   logic [2:0]        state_q, state_d;
   logic [IDX_W-1:0]  k_index_q, k_index_d;
   logic              first_flag_q, first_flag_d;
   logic [BCNT_W-1:0] blk_cnt_q, blk_cnt_d;
   logic              last_q, last_d;
   logic              accept;
   logic              halt;

`ifdef SHA_ROUND_HALT_EN
   assign halt = bus.round_halt;
`else
   assign halt = 1'b0;
`endif

   // A block is taken only in IDLE and never while reset is asserted.
   assign accept = bus.blk_valid && !rst && (state_q == S_IDLE);

   // Next-state and bookkeeping for the block/message sequence.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      k_index_d    = k_index_q;
      first_flag_d = first_flag_q;
      blk_cnt_d    = blk_cnt_q;
      last_d       = last_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_LOAD;
               last_d  = bus.blk_last;
               if (first_flag_q) begin
                  first_flag_d = 1'b0;
                  blk_cnt_d    = BCNT_W'(1);
               end else if (blk_cnt_q != '1) begin
                  blk_cnt_d = blk_cnt_q + 1'b1;
               end
            end
         end
         S_LOAD: begin
            state_d   = S_ROUND;
            k_index_d = '0;
         end
         S_ROUND: begin
            if (!halt) begin
               if (k_index_q == LAST_T) begin
                  state_d   = S_ADD;
                  k_index_d = '0;
               end else begin
                  k_index_d = k_index_q + 1'b1;
               end
            end
         end
         S_ADD: begin
            state_d = last_q ? S_OUT : S_IDLE;
         end
         S_OUT: begin
            if (bus.digest_ready) begin
               state_d      = S_IDLE;
               first_flag_d = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts any block in flight.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
      if (rst) begin
         state_q      <= S_IDLE;
         k_index_q    <= '0;
         first_flag_q <= 1'b1;
         blk_cnt_q    <= '0;
         last_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_index_q    <= k_index_d;
         first_flag_q <= first_flag_d;
         blk_cnt_q    <= blk_cnt_d;
         last_q       <= last_d;
      end
   end

   // Strobe decode from the current state; everything is silenced during reset.
   always_comb begin
      bus.blk_ready    = !rst && (state_q == S_IDLE);
      bus.hash_init    = accept && first_flag_q;
      bus.state_load   = !rst && (state_q == S_LOAD);
      bus.round_en     = !rst && (state_q == S_ROUND) && !halt;
      bus.w_load       = bus.round_en && (k_index_q <  LOAD_ROUNDS);
      bus.w_expand     = bus.round_en && (k_index_q >= LOAD_ROUNDS);
      bus.hash_add     = !rst && (state_q == S_ADD);
      bus.digest_valid = !rst && (state_q == S_OUT);
      bus.busy         = !rst && (state_q != S_IDLE);
      bus.k_index      = k_index_q;
      bus.blk_cnt      = blk_cnt_q;
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl. A behavioural SHA-256 datapath
// driven only by the controller strobes produces the digest, which a
// scoreboard compares with the published FIPS 180-2 vectors. A second,
// small instance (ROUNDS=20, BCNT_W=2) covers short rounds and blk_cnt saturation.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

   localparam int ROUNDS   = 64;
   localparam int IDX_W    = 6;
   localparam int BCNT_W   = 16;
   localparam int S_ROUNDS = 20;
   localparam int S_IDX_W  = 5;
   localparam int S_BCNT_W = 2;
   localparam int TIMEOUT  = 400;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Padded message blocks and their reference digests.
   localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [511:0] M2_B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] M2_B2 = {{15{32'h0}}, 32'h000001c0};
   localparam logic [255:0] M2_DIG =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   typedef struct {
      int add_cyc;
      bit last;
   } exp_blk_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sha256_round_ctrl_if #(.IDX_W(IDX_W),   .BCNT_W(BCNT_W))   bus  ();
   sha256_round_ctrl_if #(.IDX_W(S_IDX_W), .BCNT_W(S_BCNT_W)) sbus ();

   sha256_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W), .BCNT_W(BCNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sha256_round_ctrl #(.ROUNDS(S_ROUNDS), .IDX_W(S_IDX_W), .BCNT_W(S_BCNT_W)) u_small (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   int n_checks = 0;
   int n_errors = 0;

   exp_blk_t       blk_q [$];
   logic [255:0]   dig_q [$];
   logic [31:0]    cur_blk [16];
   logic [31:0]    hh [8];
   logic [31:0]    wr [8];
   logic [31:0]    wsch [64];
   int             cyc = 0;
   int             exp_t = 0;
   int             exp_dv_cyc = -1;
   bit             exp_first = 1'b1;
   bit             in_round = 1'b0;
   bit             prev_dv = 1'b0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Datapath model plus scoreboard for the full-size instance.
   initial begin : monitor
      exp_blk_t    e;
      logic [31:0] wt, t1, t2;
      int          ti;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            check("rst_quiet", {bus.round_en, bus.state_load, bus.hash_add, bus.hash_init,
                                bus.digest_valid, bus.busy, bus.blk_ready}, 7'b0);
            blk_q.delete();
            dig_q.delete();
            exp_first  = 1'b1;
            in_round   = 1'b0;
            exp_t      = 0;
            prev_dv    = 1'b0;
            exp_dv_cyc = -1;
            continue;
         end
         check("strobe_excl", int'(bus.state_load) + int'(bus.round_en) + int'(bus.hash_add)
                              + int'(bus.digest_valid) <= 1, 1'b1);
`ifdef SHA_ROUND_HALT_EN
         if (in_round && !bus.hash_add && bus.round_halt && blk_q.size() > 0)
            blk_q[0].add_cyc++;
`endif
         if (bus.blk_valid && bus.blk_ready) begin
            check("hash_init", bus.hash_init, exp_first);
            exp_first = 1'b0;
            blk_q.push_back('{add_cyc: cyc + ROUNDS + 2, last: bus.blk_last});
         end else if (bus.hash_init) begin
            check("hash_init_no_accept", bus.hash_init, 1'b0);
         end
         if (bus.hash_init) hh = IV;
         if (bus.state_load) begin
            check("load_k_index", bus.k_index, 0);
            wr       = hh;
            exp_t    = 0;
            in_round = 1'b1;
         end
         if (bus.round_en) begin
            check("k_index", bus.k_index, exp_t);
            check("w_sel", {bus.w_load, bus.w_expand}, (exp_t < 16) ? 2'b10 : 2'b01);
            ti = int'(bus.k_index);
            if (bus.w_load)
               wt = (ti < 16) ? cur_blk[ti] : 32'h0;
            else
               wt = (ti >= 16) ? ssig1(wsch[ti-2]) + wsch[ti-7] + ssig0(wsch[ti-15]) + wsch[ti-16] : 32'h0;
            wsch[ti] = wt;
            t1 = wr[7] + bsig1(wr[4]) + ((wr[4] & wr[5]) ^ (~wr[4] & wr[6])) + K_TAB[ti] + wt;
            t2 = bsig0(wr[0]) + ((wr[0] & wr[1]) ^ (wr[0] & wr[2]) ^ (wr[1] & wr[2]));
            wr[7] = wr[6]; wr[6] = wr[5]; wr[5] = wr[4]; wr[4] = wr[3] + t1;
            wr[3] = wr[2]; wr[2] = wr[1]; wr[1] = wr[0]; wr[0] = t1 + t2;
            exp_t++;
         end else begin
            check("w_sel_idle", {bus.w_load, bus.w_expand}, 2'b00);
         end
         if (bus.hash_add) begin
            if (blk_q.size() == 0) begin
               check("spurious_hash_add", bus.hash_add, 1'b0);
            end else begin
               e = blk_q.pop_front();
               check("add_latency", cyc, e.add_cyc);
               check("rounds_done", exp_t, ROUNDS);
               for (int i = 0; i < 8; i++) hh[i] = hh[i] + wr[i];
               in_round = 1'b0;
               if (e.last) exp_dv_cyc = cyc + 1;
            end
         end
         if (bus.digest_valid && !prev_dv) begin
            check("dv_cycle", cyc, exp_dv_cyc);
            if (dig_q.size() == 0)
               check("spurious_digest", bus.digest_valid, 1'b0);
            else
               check("digest", {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]}, dig_q.pop_front());
         end
         if (bus.digest_valid && bus.digest_ready) exp_first = 1'b1;
         prev_dv = bus.digest_valid;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_block(input logic [511:0] blk, input bit last, input bit has_dig,
                             input logic [255:0] dig);
      int n = 0;
      while (!bus.blk_ready && n < TIMEOUT) begin
         step();
         n++;
      end
      check("ready_wait", bus.blk_ready, 1'b1);
      for (int i = 0; i < 16; i++) cur_blk[i] = blk[511 - 32*i -: 32];
      if (has_dig) dig_q.push_back(dig);
      bus.blk_valid = 1'b1;
      bus.blk_last  = last;
      step();
      bus.blk_valid = 1'b0;
      bus.blk_last  = !last;
   endtask

   task automatic wait_dv();
      int n = 0;
      while (!bus.digest_valid && n < TIMEOUT) begin
         step();
         n++;
      end
      check("dv_wait", bus.digest_valid, 1'b1);
   endtask

   task automatic take_digest();
      bus.digest_ready = 1'b1;
      step();
      bus.digest_ready = 1'b0;
      #1;
      check("idle_after_take", {bus.busy, bus.blk_ready}, 2'b01);
   endtask

   task automatic wait_round(input int t);
      int n = 0;
      while (!(bus.round_en && int'(bus.k_index) == t) && n < TIMEOUT) begin
         step();
         n++;
      end
      check("reach_round", bus.k_index, t);
   endtask

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      int n, kmax;
      rst               = 1'b1;
      bus.blk_valid     = 1'b0;
      bus.blk_last      = 1'b0;
      bus.digest_ready  = 1'b0;
      sbus.blk_valid    = 1'b0;
      sbus.blk_last     = 1'b0;
      sbus.digest_ready = 1'b0;
`ifdef SHA_ROUND_HALT_EN
      bus.round_halt    = 1'b0;
      sbus.round_halt   = 1'b0;
`endif
      step();
      check("ready_in_rst", bus.blk_ready, 1'b0);
      step();
      rst = 1'b0;
      #1;
      check("rst_k_index", bus.k_index, 0);
      check("rst_blk_cnt", bus.blk_cnt, 0);
      check("rst_flags", {bus.busy, bus.digest_valid, bus.blk_ready}, 3'b001);
      check("rst_s_blk_cnt", sbus.blk_cnt, 0);

      // Single-block "abc".
      send_block(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      wait_dv();
      check("blk_cnt_abc", bus.blk_cnt, 1);

      // Digest held while the consumer stalls; the waiting block is not taken.
      for (int i = 0; i < 16; i++) cur_blk[i] = M2_B1[511 - 32*i -: 32];
      dig_q.push_back(M2_DIG);
      bus.blk_valid = 1'b1;
      bus.blk_last  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_dv_ready", {bus.digest_valid, bus.blk_ready, bus.hash_init}, 3'b100);
      end
      check("stall_blk_cnt", bus.blk_cnt, 1);
      bus.digest_ready = 1'b1;
      step();
      bus.digest_ready = 1'b0;
      #1;
      check("new_msg_accept", {bus.blk_ready, bus.hash_init}, 2'b11);
      step();
      bus.blk_valid = 1'b0;
      bus.blk_last  = 1'b1;

      // Second block of the 448-bit message.
      send_block(M2_B2, 1'b1, 1'b0, '0);
      wait_dv();
      check("blk_cnt_two", bus.blk_cnt, 2);
      take_digest();

      // Reset in the middle of the rounds.
      send_block(ABC_BLK, 1'b0, 1'b0, '0);
      wait_round(30);
      rst = 1'b1;
      #1;
      check("mid_rst_quiet", {bus.round_en, bus.busy, bus.blk_ready}, 3'b000);
      step();
      rst = 1'b0;
      #1;
      check("mid_rst_idle", {bus.busy, bus.blk_ready}, 2'b01);
      check("mid_rst_k_index", bus.k_index, 0);
      for (int i = 0; i < ROUNDS + 5; i++) step();
      send_block(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      wait_dv();
      take_digest();

`ifdef SHA_ROUND_HALT_EN
      // Five-cycle freeze at t=20.
      send_block(ABC_BLK, 1'b1, 1'b1, ABC_DIG);
      wait_round(20);
      bus.round_halt = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("halt_hold", {bus.round_en, bus.k_index}, {1'b0, 6'd20});
         step();
      end
      bus.round_halt = 1'b0;
      wait_dv();
      take_digest();
`endif

      // Small instance: short round count and block-counter saturation.
      for (int b = 0; b < 5; b++) begin
         n = 0;
         while (!sbus.blk_ready && n < TIMEOUT) begin
            step();
            n++;
         end
         check("s_ready_wait", sbus.blk_ready, 1'b1);
         sbus.blk_valid = 1'b1;
         #1;
         check("s_hash_init", sbus.hash_init, b == 0);
         step();
         sbus.blk_valid = 1'b0;
         n    = 1;
         kmax = 0;
         while (!sbus.hash_add && n < TIMEOUT) begin
            if (sbus.round_en && int'(sbus.k_index) > kmax) kmax = int'(sbus.k_index);
            step();
            n++;
         end
         check("s_add_latency", n, S_ROUNDS + 2);
         check("s_kmax", kmax, S_ROUNDS - 1);
         check("s_blk_cnt", sbus.blk_cnt, (b + 1 > 3) ? 3 : b + 1);
      end
      step();
      check("s_idle_no_digest", {sbus.digest_valid, sbus.busy}, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
